// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter for the shared SoC bus. Only one transfer is
// in flight at a time, and a watchdog completes any transfer the bus never acks.
module bus_arb2 #(
    parameter int          TIMEOUT      = 256,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_l_in,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        bus_re,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic [31:0] timeout_addr
);

    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        r_state;
    logic          r_last_grant;
    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;
    logic [31:0]   r_timeout_addr;

    logic          w_active;
    logic          w_sel;
    logic          w_valid;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic          w_done;
    logic          w_expire;
    logic          w_ready;
    logic [31:0]   w_rdata;

    // Granted master's live request, muxed once and shared by all outputs.
    always_comb begin
        w_active = (r_state == GNT0) || (r_state == GNT1);
        w_sel    = (r_state == GNT1);
        w_valid  = w_active && (w_sel ? m1_valid : m0_valid);
        w_addr   = w_sel ? m1_addr  : m0_addr;
        w_wdata  = w_sel ? m1_wdata : m0_wdata;
        w_wstrb  = w_sel ? m1_wstrb : m0_wstrb;
        w_done   = w_valid && bus_ack;
        w_expire = w_valid && !bus_ack && (r_cnt == CNT_LAST);
        w_ready  = w_done || w_expire;
        w_rdata  = w_done ? bus_rdata : TIMEOUT_DATA;
    end

    always_comb begin
        bus_re       = w_valid && !w_expire;
        bus_we       = w_valid ? w_wstrb : 4'h0;
        bus_addr     = w_active ? w_addr  : 32'h0;
        bus_wdata    = w_active ? w_wdata : 32'h0;
        m0_ready     = w_ready && !w_sel;
        m1_ready     = w_ready && w_sel;
        m0_rdata     = m0_ready ? w_rdata : 32'h0;
        m1_rdata     = m1_ready ? w_rdata : 32'h0;
        timeout_err  = r_timeout_err;
        timeout_addr = r_timeout_addr;
    end

    always_ff @(posedge clk or negedge reset_l_in) begin
        if (!reset_l_in) begin
            r_state        <= IDLE;
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
            r_timeout_err  <= 1'b0;
            r_timeout_addr <= 32'h0;
        end else begin
            // A timeout in the same cycle as err_clr keeps the error set.
            if (w_expire) begin
                r_timeout_err  <= 1'b1;
                r_timeout_addr <= w_addr;
            end else if (err_clr) begin
                r_timeout_err  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (m0_valid && m1_valid)
                        r_state <= r_last_grant ? GNT0 : GNT1;
                    else if (m0_valid)
                        r_state <= GNT0;
                    else if (m1_valid)
                        r_state <= GNT1;
                end
                default: begin
                    if (!w_valid) begin
                        r_state <= IDLE;
                    end else if (w_ready) begin
                        r_state      <= IDLE;
                        r_last_grant <= w_sel;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: directed scenarios with literal expectations, then a
// randomized run, all checked every cycle against a transaction-level model.
module tb_bus_arb2;

    localparam int          TO = 4;
    localparam logic [31:0] TD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_l_in = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic        timeout_err;
    logic [31:0] timeout_addr;

    bus_arb2 #(.TIMEOUT(TO), .TIMEOUT_DATA(TD)) dut (
        .clk(clk), .reset_l_in(reset_l_in),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err_clr(err_clr),
        .timeout_err(timeout_err), .timeout_addr(timeout_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Master agents and bookkeeping
    bit          rnd = 0;
    bit          clr_req = 0;
    bit          pend[2];
    bit          ready_seen[2];
    logic [31:0] q_addr[2], q_wdata[2];
    logic [3:0]  q_wstrb[2];
    int          done_cnt[2];
    logic [31:0] got[2];
    int          order[$];
    int          re_cnt = 0;
    logic [3:0]  cap_we;
    logic [31:0] cap_wdata;

    // Slave model
    logic [31:0] mem[16];
    bit          busy = 0;
    int          scnt = 0, sdelay = 0;
    logic [31:0] saddr, swd;
    logic [3:0]  swe;

    // Reference model: who owns the bus, for how long, who won last
    int          own = -1, age = 0, last = 1;
    logic        merr = 1'b0;
    logic [31:0] meaddr = '0;

    always @(negedge clk) begin
        logic        v, e_re, e_rdy0, e_rdy1, timed;
        logic [3:0]  e_we;
        logic [31:0] a, e_addr, e_wdata, e_rd, n_eaddr;
        int          nxt;
        if (!reset_l_in) begin
            chk("rst_bus_re", 32'(bus_re), 0);
            chk("rst_bus_we", 32'(bus_we), 0);
            chk("rst_bus_addr", bus_addr, 0);
            chk("rst_bus_wdata", bus_wdata, 0);
            chk("rst_ready", 32'({m0_ready, m1_ready}), 0);
            chk("rst_rdata", m0_rdata | m1_rdata, 0);
            chk("rst_terr", 32'(timeout_err), 0);
            chk("rst_taddr", timeout_addr, 0);
            own = -1; age = 0; last = 1; merr = 0; meaddr = 0;
        end else begin
            e_re = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rd = 0;
            e_rdy0 = 0; e_rdy1 = 0; timed = 0; n_eaddr = 0; nxt = own;
            if (own >= 0) begin
                v       = (own == 1) ? m1_valid : m0_valid;
                a       = (own == 1) ? m1_addr  : m0_addr;
                e_addr  = a;
                e_wdata = (own == 1) ? m1_wdata : m0_wdata;
                nxt     = -1;
                if (v) begin
                    e_we = (own == 1) ? m1_wstrb : m0_wstrb;
                    if (bus_ack) begin
                        e_re = 1; e_rd = bus_rdata;
                        if (own == 1) e_rdy1 = 1; else e_rdy0 = 1;
                        last = own;
                    end else if (age == TO - 1) begin
                        e_rd = TD; timed = 1; n_eaddr = a;
                        if (own == 1) e_rdy1 = 1; else e_rdy0 = 1;
                        last = own;
                    end else begin
                        e_re = 1; age++; nxt = own;
                    end
                end
            end else begin
                age = 0;
                if (m0_valid && m1_valid) nxt = 1 - last;
                else if (m0_valid) nxt = 0;
                else if (m1_valid) nxt = 1;
            end
            chk("bus_re", 32'(bus_re), 32'(e_re));
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wdata", bus_wdata, e_wdata);
            chk("m0_ready", 32'(m0_ready), 32'(e_rdy0));
            chk("m0_rdata", m0_rdata, e_rdy0 ? e_rd : 32'h0);
            chk("m1_ready", 32'(m1_ready), 32'(e_rdy1));
            chk("m1_rdata", m1_rdata, e_rdy1 ? e_rd : 32'h0);
            chk("timeout_err", 32'(timeout_err), 32'(merr));
            chk("timeout_addr", timeout_addr, meaddr);
            if (timed) begin merr = 1; meaddr = n_eaddr; end
            else if (err_clr) merr = 0;
            own = nxt;
        end
        if (bus_re) begin re_cnt++; cap_we = bus_we; cap_wdata = bus_wdata; end
        if (m0_ready) begin done_cnt[0]++; got[0] = m0_rdata; order.push_back(0); ready_seen[0] = 1; end
        if (m1_ready) begin done_cnt[1]++; got[1] = m1_rdata; order.push_back(1); ready_seen[1] = 1; end
    end

    // Slave: commits to an ack sdelay cycles after bus_re rises; 0x04xx_xxxx is unmapped
    always @(posedge clk) begin
        #2;
        if (!reset_l_in) begin
            busy = 0; bus_ack = 0;
        end else begin
            if (!busy && bus_re) begin
                busy = 1; scnt = 0; saddr = bus_addr; swe = bus_we; swd = bus_wdata;
                if (rnd) sdelay = $urandom_range(0, 5);
            end
            if (busy && saddr[31:24] != 8'h04 && scnt == sdelay) begin
                bus_ack = 1; bus_rdata = mem[saddr[5:2]];
                if (swe != 4'h0) mem[saddr[5:2]] = swd;
                busy = 0;
            end else begin
                if (busy && !bus_re && scnt > 0) busy = 0;
                bus_ack   = !busy && rnd && ($urandom_range(0, 3) == 0);
                bus_rdata = rnd ? $urandom : 32'h0;
                if (busy) scnt++;
            end
        end
    end

    task automatic new_rand(int m);
        int r = $urandom_range(0, 3);
        pend[m]    = 1;
        q_addr[m]  = (r == 1) ? 32'h0300_0000 : (r == 2) ? (32'h0400_0000 | 32'($urandom_range(0, 255)))
                                                         : 32'($urandom_range(0, 63));
        q_wdata[m] = $urandom;
        q_wstrb[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    task automatic step();
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            if (ready_seen[m]) begin pend[m] = 0; ready_seen[m] = 0; end
            if (rnd) begin
                if (pend[m] && $urandom_range(0, 49) == 0) pend[m] = 0;
                else if (!pend[m] && $urandom_range(0, 2) == 0) new_rand(m);
            end
        end
        err_clr  = rnd ? ($urandom_range(0, 7) == 0) : clr_req;
        m0_valid = pend[0]; m0_addr = q_addr[0]; m0_wdata = q_wdata[0]; m0_wstrb = q_wstrb[0];
        m1_valid = pend[1]; m1_addr = q_addr[1]; m1_wdata = q_wdata[1]; m1_wstrb = q_wstrb[1];
    endtask

    task automatic issue(int m, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        pend[m] = 1; ready_seen[m] = 0; q_addr[m] = a; q_wdata[m] = d; q_wstrb[m] = s;
    endtask

    task automatic wait_done(int m, string nm);
        int start = done_cnt[m];
        int i = 0;
        while (done_cnt[m] == start && i < 20) begin
            step(); @(negedge clk); #1; i++;
        end
        chk({nm, "_done"}, 32'(done_cnt[m] != start), 1);
    endtask

    task automatic settle();
        step(); @(negedge clk); #1;
    endtask

    initial begin
        int d1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; ready_seen[m] = 0; done_cnt[m] = 0;
            q_addr[m] = 0; q_wdata[m] = 0; q_wstrb[m] = 0; got[m] = 0;
        end
        repeat (3) @(negedge clk);
        #2 reset_l_in = 1'b1;

        // Simultaneous requests right after reset: 0, 1, then 0, 1 again
        sdelay = 1; order.delete();
        issue(0, 32'h0000_0010, 0, 4'h0); issue(1, 32'h0000_0014, 0, 4'h0);
        wait_done(0, "rr_a0"); wait_done(1, "rr_a1");
        issue(0, 32'h0000_0010, 0, 4'h0); issue(1, 32'h0000_0014, 0, 4'h0);
        wait_done(0, "rr_b0"); wait_done(1, "rr_b1");
        chk("rr_count", 32'(order.size()), 4);
        if (order.size() == 4) begin
            chk("rr_order0", 32'(order[0]), 0); chk("rr_order1", 32'(order[1]), 1);
            chk("rr_order2", 32'(order[2]), 0); chk("rr_order3", 32'(order[3]), 1);
        end
        settle();

        // Single read, acked 2 cycles after bus_re rises
        mem[0] = 32'h1234_5678; sdelay = 2; re_cnt = 0; d1 = done_cnt[1];
        issue(0, 32'h0001_0000, 0, 4'h0);
        wait_done(0, "rd");
        chk("rd_re_cycles", 32'(re_cnt), 3);
        chk("rd_rdata", got[0], 32'h1234_5678);
        chk("rd_m1_quiet", 32'(done_cnt[1] - d1), 0);
        settle();

        // Master 1 write to the LED register, then read it back
        sdelay = 1;
        issue(1, 32'h0300_0000, 32'h0000_00A5, 4'hF);
        wait_done(1, "wr");
        chk("wr_we", 32'(cap_we), 32'hF);
        chk("wr_wdata", cap_wdata, 32'hA5);
        settle();
        issue(0, 32'h0300_0000, 0, 4'h0);
        wait_done(0, "led_rd");
        chk("led_rdata", got[0], 32'hA5);
        settle();

        // Unmapped read times out on the 4th grant cycle
        re_cnt = 0;
        issue(0, 32'h0400_0000, 0, 4'h0);
        wait_done(0, "to");
        chk("to_rdata", got[0], 32'hDEAD_BEEF);
        chk("to_re_cycles", 32'(re_cnt), 3);
        settle();
        chk("to_err", 32'(timeout_err), 1);
        chk("to_addr", timeout_addr, 32'h0400_0000);
        clr_req = 1; step(); clr_req = 0; settle();
        chk("to_cleared", 32'(timeout_err), 0);

        // Ack on the expiry cycle wins
        mem[1] = 32'h11; sdelay = 3;
        issue(0, 32'h0000_0004, 0, 4'h0);
        wait_done(0, "tie");
        chk("tie_rdata", got[0], 32'h11);
        settle();
        chk("tie_no_err", 32'(timeout_err), 0);

        // Reset mid-grant, then master 0 wins a tie
        issue(0, 32'h0400_0000, 0, 4'h0);
        settle(); settle();
        chk("pre_rst_re", 32'(bus_re), 1);
        @(posedge clk); #3;
        reset_l_in = 1'b0;
        pend[0] = 0; pend[1] = 0; m0_valid = 0; m1_valid = 0;
        #1;
        chk("async_rst_re", 32'(bus_re), 0);
        chk("async_rst_addr", bus_addr, 0);
        chk("async_rst_ready", 32'(m0_ready), 0);
        @(negedge clk); #2;
        reset_l_in = 1'b1;
        ready_seen[0] = 0; ready_seen[1] = 0;
        sdelay = 0; order.delete();
        issue(0, 32'h0000_0008, 0, 4'h0); issue(1, 32'h0000_000C, 0, 4'h0);
        wait_done(0, "post_rst0"); wait_done(1, "post_rst1");
        chk("post_rst_first", (order.size() > 0) ? 32'(order[0]) : 32'hFFFF_FFFF, 0);

        // Randomized traffic
        rnd = 1;
        repeat (3000) step();
        rnd = 0; pend[0] = 0; pend[1] = 0;
        repeat (10) step();
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
